// File: rtl/prod_requant_acc.sv
// Sign-magnitude product accumulator with saturating sum and round/shift/clamp requantization
// to an 8-bit sign-magnitude result. Define PROD_REQUANT_RELU_EN to zero negative results.
module prod_requant_acc #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned SHIFT = 7
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iValid,
    output logic        oReady,
    input  logic [14:0] iProd,
    input  logic        iLast,
    output logic        oValid,
    input  logic        iReady,
    output logic [7:0]  oNum,
    output logic        oOvf
);

    typedef enum logic [1:0] {StAccum, StRound, StHold} state_e;

    localparam logic signed [ACC_W:0] AccMax  = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] AccMin  = -AccMax;
    localparam logic [ACC_W:0]        RndHalf = (ACC_W+1)'((32'd1 << SHIFT) >> 1);

    state_e             state_q, state_d;
    logic               phase_q, phase_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W:0]     rmag_q, rmag_d;
    logic               neg_q, neg_d;
    logic [7:0]         num_q, num_d;
    logic               res_ovf_q, res_ovf_d;

    logic signed [ACC_W:0] beat_s, sum_s, sat_sum, acc_ext;
    logic                  sat_hit;
    logic [ACC_W:0]        abs_acc, shifted;
    logic                  clamp;
    logic [6:0]            mag7;
    logic [7:0]            num_res;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= StAccum;
            phase_q   <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            rmag_q    <= '0;
            neg_q     <= 1'b0;
            num_q     <= 8'h00;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            rmag_q    <= rmag_d;
            neg_q     <= neg_d;
            num_q     <= num_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    // Datapath: saturating add in ACCUM, two-stage round then shift/clamp in ROUND.
    always_comb begin
        beat_s = signed'({{(ACC_W-13){1'b0}}, iProd[13:0]});
        if (iProd[14]) begin
            beat_s = -beat_s;
        end
        sum_s   = signed'({acc_q[ACC_W-1], acc_q}) + beat_s;
        sat_sum = sum_s;
        sat_hit = 1'b0;
        if (sum_s > AccMax) begin
            sat_sum = AccMax;
            sat_hit = 1'b1;
        end else if (sum_s < AccMin) begin
            sat_sum = AccMin;
            sat_hit = 1'b1;
        end

        acc_ext = signed'({acc_q[ACC_W-1], acc_q});
        abs_acc = acc_q[ACC_W-1] ? unsigned'(-acc_ext) : unsigned'(acc_ext);

        shifted = rmag_q >> SHIFT;
        clamp   = shifted > (ACC_W+1)'(127);
        mag7    = clamp ? 7'h7f : shifted[6:0];
`ifdef PROD_REQUANT_RELU_EN
        num_res = neg_q ? 8'h00 : {1'b0, mag7};
`else
        // Zero magnitude never carries the sign: 0x80 is reserved downstream.
        num_res = {neg_q && (mag7 != 7'd0), mag7};
`endif
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        rmag_d    = rmag_q;
        neg_d     = neg_q;
        num_d     = num_q;
        res_ovf_d = res_ovf_q;
        unique case (state_q)
            StAccum: begin
                if (iValid) begin
                    acc_d = sat_sum[ACC_W-1:0];
                    ovf_d = ovf_q | sat_hit;
                    if (iLast) begin
                        state_d = StRound;
                        phase_d = 1'b0;
                    end
                end
            end
            StRound: begin
                if (!phase_q) begin
                    rmag_d  = abs_acc + RndHalf;
                    neg_d   = acc_q[ACC_W-1];
                    phase_d = 1'b1;
                end else begin
                    num_d     = num_res;
                    res_ovf_d = ovf_q | clamp;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (iReady) begin
                    state_d = StAccum;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_comb begin
        oReady = (state_q == StAccum);
        oValid = (state_q == StHold);
        oNum   = num_q;
        oOvf   = res_ovf_q;
    end

endmodule

// File: tb/tb_prod_requant_acc.sv
// Randomized and directed bench for prod_requant_acc against a plain-arithmetic reference model.
module tb_prod_requant_acc;

    localparam int ACC_W = 24;
    localparam int SHIFT = 7;
`ifdef PROD_REQUANT_RELU_EN
    localparam bit Relu = 1'b1;
`else
    localparam bit Relu = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iValid = 1'b0;
    logic        oReady;
    logic [14:0] iProd = '0;
    logic        iLast = 1'b0;
    logic        oValid;
    logic        iReady = 1'b0;
    logic [7:0]  oNum;
    logic        oOvf;

    int n_cmp = 0;
    int n_fail = 0;

    logic [14:0] beats_q[$];
    logic [8:0]  exp_q[$];

    always #5 iClk = ~iClk;

    prod_requant_acc #(
        .ACC_W(ACC_W),
        .SHIFT(SHIFT)
    ) dut (
        .iClk  (iClk),
        .iRst_n(iRst_n),
        .iValid(iValid),
        .oReady(oReady),
        .iProd (iProd),
        .iLast (iLast),
        .oValid(oValid),
        .iReady(iReady),
        .oNum  (oNum),
        .oOvf  (oOvf)
    );

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: exact signed sum with saturation, then round half away from zero on magnitude.
    function automatic logic [8:0] model();
        longint sum, lim, v, mag, r;
        bit ovf, neg;
        sum = 0;
        ovf = 1'b0;
        lim = (longint'(1) << (ACC_W - 1)) - 1;
        foreach (beats_q[i]) begin
            v = longint'(beats_q[i][13:0]);
            if (beats_q[i][14]) v = -v;
            sum = sum + v;
            if (sum > lim) begin
                sum = lim;
                ovf = 1'b1;
            end else if (sum < -lim) begin
                sum = -lim;
                ovf = 1'b1;
            end
        end
        neg = (sum < 0);
        mag = neg ? -sum : sum;
        r = (mag + ((longint'(1) << SHIFT) >> 1)) >> SHIFT;
        if (r > 127) begin
            r = 127;
            ovf = 1'b1;
        end
        if (r == 0 || (neg && Relu)) return {ovf, 8'h00};
        return {ovf, neg, r[6:0]};
    endfunction

    // Every cycle a result is presented it must match the oldest outstanding expectation.
    always @(negedge iClk) begin
        if (iRst_n && oValid) begin
            check("num_not_0x80", longint'(oNum == 8'h80), 0);
            check("ready_low_in_hold", longint'(oReady), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got oNum=0x%0h, required no result", oNum);
            end else begin
                check("oNum", longint'(oNum), longint'(exp_q[0][7:0]));
                check("oOvf", longint'(oOvf), longint'(exp_q[0][8]));
            end
        end
    end

    always @(posedge iClk) begin
        if (iRst_n && oValid && iReady && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    task automatic send_beat(input logic [14:0] p, input bit last, output bit ok);
        int w;
        w = 0;
        iValid = 1'b1;
        iProd  = p;
        iLast  = last;
        while (!oReady && w < 50) begin
            @(negedge iClk);
            w++;
        end
        ok = oReady;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: oReady=0, required 1");
        end else begin
            @(negedge iClk);
        end
        iValid = 1'b0;
        iLast  = 1'b0;
        iProd  = 15'($urandom);
    endtask

    // Drives beats_q as one dot product, checks latency, stalls hold_cyc cycles, then consumes.
    task automatic run_dot(input bit use_lit, input logic [8:0] lit, input int hold_cyc,
                           input int gap_max);
        logic [8:0] e;
        bit ok;
        e = model();
        if (use_lit) begin
            check("model_vs_literal", longint'(e), longint'(lit));
            e = lit;
        end
        foreach (beats_q[i]) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge iClk);
            if (i == beats_q.size() - 1) exp_q.push_back(e);
            send_beat(beats_q[i], i == beats_q.size() - 1, ok);
            if (!ok) begin
                exp_q.delete();
                return;
            end
        end
        check("lat_edge0_valid", longint'(oValid), 0);
        check("lat_edge0_ready", longint'(oReady), 0);
        @(negedge iClk);
        check("lat_edge1_valid", longint'(oValid), 0);
        @(negedge iClk);
        check("lat_edge2_valid", longint'(oValid), 1);
        repeat (hold_cyc) begin
            iValid = 1'($urandom);
            iProd  = 15'($urandom);
            iLast  = 1'($urandom);
            @(negedge iClk);
            check("hold_valid", longint'(oValid), 1);
        end
        iValid = 1'b0;
        iLast  = 1'b0;
        iReady = 1'b1;
        @(negedge iClk);
        iReady = 1'b0;
        check("consumed_valid", longint'(oValid), 0);
        check("consumed_ready", longint'(oReady), 1);
    endtask

    task automatic do_reset();
        iRst_n = 1'b0;
        iValid = 1'b0;
        iReady = 1'b0;
        iLast  = 1'b0;
        #2;
        check("rst_valid", longint'(oValid), 0);
        check("rst_num", longint'(oNum), 0);
        check("rst_ovf", longint'(oOvf), 0);
        exp_q.delete();
        @(negedge iClk);
        @(negedge iClk);
        iRst_n = 1'b1;
        #1;
        check("rst_ready", longint'(oReady), 1);
    endtask

    initial begin
        bit ok;
        @(negedge iClk);
        do_reset();

        beats_q = '{15'h1000};
        run_dot(1'b1, 9'h020, 0, 0);
        beats_q = '{15'h1000, 15'h5000};
        run_dot(1'b1, 9'h000, 0, 1);
        beats_q = '{15'h0040};
        run_dot(1'b1, 9'h001, 0, 0);
        beats_q = '{15'h4040};
        run_dot(1'b1, Relu ? 9'h000 : 9'h081, 0, 0);
        beats_q = '{15'h3FFF, 15'h3FFF, 15'h3FFF, 15'h3FFF};
        run_dot(1'b1, 9'h17F, 0, 0);
        beats_q = '{15'h0123, 15'h4000};
        run_dot(1'b1, 9'h002, 5, 0);

        // Accumulator saturation in both directions.
        beats_q.delete();
        repeat (520) beats_q.push_back(15'h3FFF);
        run_dot(1'b1, 9'h17F, 1, 0);
        beats_q.delete();
        repeat (520) beats_q.push_back(15'h7FFF);
        run_dot(1'b1, Relu ? 9'h100 : 9'h1FF, 1, 0);

        // Reset mid-dot-product discards partial sum.
        send_beat(15'h3000, 1'b0, ok);
        send_beat(15'h2000, 1'b0, ok);
        do_reset();
        beats_q = '{15'h1000};
        run_dot(1'b1, 9'h020, 0, 0);
        beats_q = '{15'h5000};
        run_dot(1'b1, Relu ? 9'h000 : 9'h0A0, 0, 0);

        // Reset while a result is held.
        exp_q.push_back(9'h17F);
        send_beat(15'h3FFF, 1'b0, ok);
        send_beat(15'h3FFF, 1'b1, ok);
        @(negedge iClk);
        @(negedge iClk);
        check("hold_before_reset", longint'(oValid), 1);
        do_reset();
        beats_q = '{15'h0040};
        run_dot(1'b1, 9'h001, 0, 0);

        for (int t = 0; t < 60; t++) begin
            int len;
            logic [14:0] b;
            len = $urandom_range(6, 1);
            beats_q.delete();
            for (int k = 0; k < len; k++) begin
                b = 15'($urandom);
                if ($urandom_range(7, 0) == 0) b[13:0] = '0;
                if ($urandom_range(7, 0) == 0) b[13:0] = 14'h3FFF;
                beats_q.push_back(b);
            end
            run_dot(1'b0, 9'h000, $urandom_range(3, 0), $urandom_range(2, 0));
        end

        check("results_drained", longint'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prod_requant_acc.md
PROD_REQUANT_ACC -- requirements
Module: prod_requant_acc

Interface
REQ-001 The block SHALL have parameter ACC_W, default 24: accumulator width in bits (signed two's complement), legal range 16..32.
REQ-002 The block SHALL have parameter SHIFT, default 7: right-shift applied to the accumulated sum before requantization, legal range 0..14.
REQ-003 The block SHALL have port iClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port iRst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port iValid, input, 1 bit: the upstream product beat is valid.
REQ-006 The block SHALL have port oReady, output, 1 bit: the block accepts a beat this cycle.
REQ-007 The block SHALL have port iProd, input, 15 bits: sign-magnitude product, where bit 14 is the sign and bits 13:0 are the magnitude.
REQ-008 The block SHALL have port iLast, input, 1 bit: this beat is the final beat of a dot product; sampled with iProd.
REQ-009 The block SHALL have port oValid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port iReady, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port oNum, output, 8 bits: sign-magnitude result, where bit 7 is the sign and bits 6:0 are the magnitude.
REQ-012 The block SHALL have port oOvf, output, 1 bit: the result saturated (accumulator or output clamp); qualified by oValid.

Function
REQ-013 A beat SHALL be accepted on a rising edge when iValid and oReady are both 1.
REQ-014 FSM states SHALL be ACCUM, ROUND and HOLD; oReady SHALL be 1 only in ACCUM.
REQ-015 In ACCUM, each accepted beat SHALL add +magnitude when the sign bit is 0 and -magnitude when it is 1; a beat with magnitude 0 SHALL contribute 0 regardless of sign.
REQ-016 The accumulator SHALL saturate at +/-(2^(ACC_W-1)-1) and set a sticky overflow flag rather than wrap.
REQ-017 An accepted beat with iLast=1 SHALL be included in the sum, and the FSM SHALL move ACCUM->ROUND.
REQ-018 ROUND SHALL compute the magnitude |acc|, round it half-away-from-zero at bit SHIFT-1, shift it right by SHIFT, clamp it to 127 (setting the overflow flag when clamped), then move ROUND->HOLD.
REQ-019 In HOLD, oValid SHALL be 1; oNum and oOvf SHALL be registered and held stable until iReady=1.
REQ-020 When iReady=1 in HOLD, the result SHALL be consumed, the accumulator and overflow flag SHALL be cleared, and the FSM SHALL move HOLD->ACCUM.
REQ-021 Latency SHALL be: oValid asserts on the 2nd rising edge after the edge accepting the iLast beat.
REQ-022 The block SHALL accept a new beat no earlier than the cycle after the result is consumed.
REQ-023 A zero result magnitude SHALL always be encoded as 0x00; 0x80 SHALL never be emitted, because it is reserved as the unity operand code of the multiplier.
REQ-024 A single-beat dot product (iLast on the first beat) SHALL be legal.
REQ-025 iValid during ROUND or HOLD SHALL be ignored (not accepted, no state change).

Reset
REQ-026 While iRst_n=0, the block SHALL force FSM=ACCUM, accumulator=0, overflow flag=0, oValid=0, oNum=0x00 and oOvf=0; oReady SHALL be 1 once iRst_n is released.
REQ-027 Assertion of iRst_n in any state, including mid-dot-product or in HOLD, SHALL discard all partial or pending results immediately.

Configuration
REQ-028 With the macro PROD_REQUANT_RELU_EN defined, a negative rounded result SHALL be output as 0x00 with oOvf unaffected.
REQ-029 Without PROD_REQUANT_RELU_EN, a negative rounded result SHALL be output with its sign bit set.

Verification
REQ-030 The bench SHALL drive one beat 0x1000 with iLast=1 and iReady=1, and SHALL check that oNum=0x20 and oOvf=0 arrive 2 cycles after acceptance.
REQ-031 The bench SHALL drive beats 0x1000 then 0x5000 (last), and SHALL check that oNum=0x00, never 0x80, is produced.
REQ-032 The bench SHALL drive single beats 0x0040 and 0x4040, and SHALL check oNum=0x01 and oNum=0x81 respectively (without RELU) for the half-way rounding cases.
REQ-033 The bench SHALL drive four beats of 0x3FFF, and SHALL check that oNum=0x7F and oOvf=1 are produced.
REQ-034 The bench SHALL hold iReady=0 for 5 cycles in HOLD, and SHALL check that oValid stays 1, oNum stays stable, oReady stays 0, and iValid beats are ignored.
REQ-035 The bench SHALL assert iRst_n low after 2 of 3 beats, and SHALL check that after release a fresh single beat 0x1000 yields 0x20 with no residue; with RELU enabled, beat 0x5000 SHALL yield 0x00.
